// File: rtl/pattern_detect_if.sv
// rtl/pattern_detect_if.sv - serial bit stream in, match flag/progress/count out
interface pattern_detect_if #(
  parameter int N     = 3,
  parameter int CNT_W = 8
);
  logic                       in_valid;
  logic                       in_bit;
  logic                       clear;
  logic                       match;
  logic [$clog2(N+1)-1:0]     progress;
  logic [CNT_W-1:0]           match_cnt;

  modport master (
    output in_valid, in_bit, clear,
    input  match, progress, match_cnt
  );

  modport slave (
    input  in_valid, in_bit, clear,
    output match, progress, match_cnt
  );
endinterface

// File: rtl/pattern_detect.sv
// rtl/pattern_detect.sv - KMP serial pattern detector; match counter enabled by PATTERN_DETECT_MATCH_CNT_EN
module pattern_detect #(
  parameter int             N       = 3,
  parameter logic [N-1:0]   PATTERN = 3'b111,
  parameter int             OVERLAP = 1,
  parameter int             CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  pattern_detect_if.slave   bus
);

  localparam int PW = $clog2(N+1);
  localparam int NS = 2**PW;

  // Next prefix length after receiving bit b in state p. The received string is
  // the first p pattern bits followed by b; the result is the longest suffix of
  // it (shorter than N) that is also a pattern prefix. A completed match folds
  // back to the longest border, or to 0 when overlaps are not wanted.
  // States outside 0..N-1 map to 0 so stray encodings self-recover.
  function automatic logic [PW-1:0] next_state(input int p, input logic b);
    logic [N-1:0] s;
    int           len;
    int           best;
    logic         ok;
    best = 0;
    s    = '0;
    if (p < N) begin
      len = p + 1;
      for (int i = 0; i < N; i++) begin
        if (i < p)
          s[i] = PATTERN[N-1-i];
        else if (i == p)
          s[i] = b;
      end
      for (int k = 1; k < N; k++) begin
        if (k <= len) begin
          ok = 1'b1;
          for (int j = 0; j < N; j++) begin
            if (j < k) begin
              if (s[len-k+j] != PATTERN[N-1-j])
                ok = 1'b0;
            end
          end
          if (ok)
            best = k;
        end
      end
      if (p == N-1 && b == PATTERN[0] && OVERLAP == 0)
        best = 0;
    end
    return PW'(best);
  endfunction

  logic [PW-1:0] nxt0 [NS];
  logic [PW-1:0] nxt1 [NS];

  for (genvar g = 0; g < NS; g++) begin : g_tbl
    localparam logic [PW-1:0] NX0 = next_state(g, 1'b0);
    localparam logic [PW-1:0] NX1 = next_state(g, 1'b1);
    assign nxt0[g] = NX0;
    assign nxt1[g] = NX1;
  end

  logic [PW-1:0] p_q;
  logic          match_q;
  logic          hit;

  assign hit = bus.in_valid && (p_q == PW'(N-1)) && (bus.in_bit == PATTERN[0]);

  // Prefix state: clear wins over data, stray encodings drop back to 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      p_q <= '0;
    else if (bus.clear)
      p_q <= '0;
    else if (bus.in_valid)
      p_q <= bus.in_bit ? nxt1[p_q] : nxt0[p_q];
    else if (p_q >= PW'(N))
      p_q <= '0;
  end

  // Match flag is a one-cycle registered pulse per completed pattern
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      match_q <= 1'b0;
    else if (bus.clear)
      match_q <= 1'b0;
    else
      match_q <= hit;
  end

  assign bus.match    = match_q;
  assign bus.progress = p_q;

`ifdef PATTERN_DETECT_MATCH_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Saturating match counter, advances on the same edge that raises match
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt_q <= '0;
    else if (bus.clear)
      cnt_q <= '0;
    else if (hit && cnt_q != '1)
      cnt_q <= cnt_q + 1'b1;
  end

  assign bus.match_cnt = cnt_q;
`else
  assign bus.match_cnt = '0;
`endif

endmodule
